// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_pkg
// Description : Shared constants and types for the spectral power integrator.
//               Holds the default geometry (bins, index width, sample width,
//               accumulator width) and the integration state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_pkg;

    localparam int c_fft_point = 512;   // bins per spectrum
    localparam int c_cnt_w     = 9;     // bin index width
    localparam int c_data_w    = 23;    // signed re/im sample width
    localparam int c_acc_w     = 64;    // accumulator / output width
    localparam int c_len_w     = 16;    // integration length width

    // Integration control states.
    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,    // waiting for bin 0 to open an integration
        ACCUM    = 1'b1     // accumulating an in-sequence bin stream
    } acc_state_e;

    // A requested length of zero integrates a single spectrum.
    function automatic logic [c_len_w-1:0] eff_len(input logic [c_len_w-1:0] len);
        return (len == '0) ? c_len_w'(1) : len;
    endfunction

endpackage : freq_pkg
`default_nettype wire

// File: rtl/freq_power_ram.sv
`default_nettype none
// ============================================================================
// Module      : freq_power_ram
// Description : Simple dual-port accumulator storage. One synchronous write
//               port and one read port with a registered (1-cycle) output.
//               Contents are not reset.
// Ports       : clk      - clock
//               we       - write enable
//               wr_addr  - write address
//               wr_data  - write data
//               rd_addr  - read address
//               rd_data  - read data, valid the cycle after rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module freq_power_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule : freq_power_ram
`default_nettype wire

// File: rtl/freq_power_acc.sv
`default_nettype none
// ============================================================================
// Module      : freq_power_acc
// Description : Integrates |X[k]|^2 over acc_len consecutive spectra into a
//               ping-pong pair of accumulator banks, then streams the result
//               out bin by bin while the next integration proceeds.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               en_sync_in     - sample valid
//               cnt_sync_in    - bin index of the sample
//               re_in, im_in   - signed equalized sample
//               acc_len        - spectra per integration (0 acts as 1)
//               out_valid      - one strobe per output bin
//               out_bin        - bin index of out_data (0 when idle)
//               out_data       - integrated power (0 when idle)
//               sync_err       - sticky: bin sequence violation seen
//               ovf_err        - sticky: result dropped, readout busy
// Revision    : 1.0 - initial release
// ============================================================================
module freq_power_acc
    import freq_pkg::*;
#(
    parameter int FFT_POINT = c_fft_point,
    parameter int CNT_W     = c_cnt_w,
    parameter int DATA_W    = c_data_w,
    parameter int ACC_W     = c_acc_w
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_sync_in,
    input  logic [CNT_W-1:0]         cnt_sync_in,
    input  logic signed [DATA_W-1:0] re_in,
    input  logic signed [DATA_W-1:0] im_in,
    input  logic [c_len_w-1:0]       acc_len,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         out_bin,
    output logic [ACC_W-1:0]         out_data,
    output logic                     sync_err,
    output logic                     ovf_err
);

    localparam logic [CNT_W-1:0] c_last_bin = CNT_W'(FFT_POINT - 1);
    localparam int               c_pwr_w    = 2 * DATA_W;

    // ------------------------------------------------------------------
    // Integration control
    // ------------------------------------------------------------------
    acc_state_e          r_state;
    acc_state_e          w_state_nxt;
    logic [c_len_w-1:0]  r_frame;       // spectrum index within integration
    logic [c_len_w-1:0]  r_len;         // latched effective length
    logic [CNT_W-1:0]    r_prev_bin;    // last accepted bin
    logic                r_sync_err;

    logic                w_start;       // sample opens a new integration
    logic                w_push;        // sample enters the datapath
    logic                w_first;       // sample belongs to frame 0
    logic                w_last;        // sample completes the integration
    logic                w_frame_inc;
    logic                w_seq_bad;
    logic [CNT_W-1:0]    w_expect_bin;
    logic                w_final_frame;

    assign w_expect_bin  = (r_prev_bin == c_last_bin) ? '0 : r_prev_bin + 1'b1;
    assign w_final_frame = (r_frame == r_len - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_frame_inc = 1'b0;
        w_seq_bad   = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                if (en_sync_in && (cnt_sync_in == '0)) begin
                    w_start     = 1'b1;
                    w_push      = 1'b1;
                    w_first     = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (en_sync_in) begin
                    if (cnt_sync_in == w_expect_bin) begin
                        w_push  = 1'b1;
                        w_first = (r_frame == '0);
                        if (cnt_sync_in == c_last_bin) begin
                            if (w_final_frame) begin
                                w_last      = 1'b1;
                                w_state_nxt = WAIT_SOF;
                            end else begin
                                w_frame_inc = 1'b1;
                            end
                        end
                    end else begin
                        // Broken sequence: drop the integration. A bin-0
                        // sample can immediately open the next one.
                        w_seq_bad = 1'b1;
                        if (cnt_sync_in == '0) begin
                            w_start = 1'b1;
                            w_push  = 1'b1;
                            w_first = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_SOF;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame    <= '0;
            r_len      <= c_len_w'(1);
            r_prev_bin <= '0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_frame <= '0;
                r_len   <= eff_len(acc_len);
            end else if (w_frame_inc) begin
                r_frame <= r_frame + 1'b1;
            end
            if (w_push) begin
                r_prev_bin <= cnt_sync_in;
            end
            if (w_seq_bad) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-modify-write pipeline: s1 input reg, s2 square, s3 sum, write
    // ------------------------------------------------------------------
    logic                r_s1_vld, r_s1_first, r_s1_last;
    logic [CNT_W-1:0]    r_s1_bin;
    logic [DATA_W-1:0]   r_s1_re, r_s1_im;
    logic                r_s2_vld, r_s2_first, r_s2_last;
    logic [CNT_W-1:0]    r_s2_bin;
    logic [c_pwr_w-1:0]  r_s2_pwr;
    logic                r_s3_vld, r_s3_last;
    logic [CNT_W-1:0]    r_s3_bin;
    logic [ACC_W-1:0]    r_s3_sum;

    logic [c_pwr_w-1:0]  w_re_ext, w_im_ext, w_pwr;
    logic [ACC_W-1:0]    w_pwr_ext;
    logic [ACC_W-1:0]    w_acc_rd;

    // Squaring the sign-extended operands modulo 2^(2*DATA_W) yields the
    // exact square; the sum peaks at 2^(2*DATA_W-1) and so still fits.
    assign w_re_ext  = {{DATA_W{r_s1_re[DATA_W-1]}}, r_s1_re};
    assign w_im_ext  = {{DATA_W{r_s1_im[DATA_W-1]}}, r_s1_im};
    assign w_pwr     = (w_re_ext * w_re_ext) + (w_im_ext * w_im_ext);
    assign w_pwr_ext = {{(ACC_W - c_pwr_w){1'b0}}, r_s2_pwr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_push;
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;
        end
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_bin   <= cnt_sync_in;
        r_s1_re    <= re_in;
        r_s1_im    <= im_in;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_bin   <= r_s1_bin;
        r_s2_pwr   <= w_pwr;
        r_s3_last  <= r_s2_last;
        r_s3_bin   <= r_s2_bin;
        // Frame 0 overwrites, so stale bank contents never need clearing.
        r_s3_sum   <= r_s2_first ? w_pwr_ext : (w_acc_rd + w_pwr_ext);
    end

    // ------------------------------------------------------------------
    // Bank swap and readout
    // ------------------------------------------------------------------
    logic               r_bank_sel;     // bank currently accumulating
    logic               r_sel_q;        // r_bank_sel as seen by last read
    logic               r_rd_active;    // readout issuing addresses
    logic [CNT_W-1:0]   r_rd_addr;
    logic               r_out_vld;
    logic [CNT_W-1:0]   r_out_bin;
    logic               r_ovf_err;

    logic               w_done;
    logic               w_rd_busy;
    logic               w_swap;
    logic [ACC_W-1:0]   w_rd_out;
    logic [ACC_W-1:0]   w_ram_rd [2];

    assign w_done    = r_s3_vld && r_s3_last;
    // A readout issuing its final address this cycle frees the bank in
    // time, letting full-rate single-spectrum integrations run back to back.
    assign w_rd_busy = r_rd_active && (r_rd_addr != c_last_bin);
    assign w_swap    = w_done && !w_rd_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_sel  <= 1'b0;
            r_sel_q     <= 1'b0;
            r_rd_active <= 1'b0;
            r_rd_addr   <= '0;
            r_out_vld   <= 1'b0;
            r_out_bin   <= '0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_sel_q   <= r_bank_sel;
            r_out_vld <= r_rd_active;
            r_out_bin <= r_rd_active ? r_rd_addr : '0;
            if (w_swap) begin
                r_bank_sel  <= ~r_bank_sel;
                r_rd_active <= 1'b1;
                r_rd_addr   <= '0;
            end else if (r_rd_active) begin
                if (r_rd_addr == c_last_bin) begin
                    r_rd_active <= 1'b0;
                    r_rd_addr   <= '0;
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end
            if (w_done && w_rd_busy) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // Read data belongs to whichever bank roles held when it was addressed.
    assign w_acc_rd = w_ram_rd[r_sel_q];
    assign w_rd_out = w_ram_rd[~r_sel_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_id = 1'(b);
        logic             w_we;
        logic [CNT_W-1:0] w_rd_addr;

        // Writes still in flight at reset are dropped.
        assign w_we      = r_s3_vld && !rst && (r_bank_sel == c_id);
        assign w_rd_addr = (r_bank_sel == c_id) ? r_s1_bin : r_rd_addr;

        freq_power_ram #(
            .DEPTH  (FFT_POINT),
            .ADDR_W (CNT_W),
            .WORD_W (ACC_W)
        ) u_ram (
            .clk     (clk),
            .we      (w_we),
            .wr_addr (r_s3_bin),
            .wr_data (r_s3_sum),
            .rd_addr (w_rd_addr),
            .rd_data (w_ram_rd[b])
        );
    end

    assign out_valid = r_out_vld;
    assign out_bin   = r_out_bin;
    assign out_data  = r_out_vld ? w_rd_out : '0;
    assign sync_err  = r_sync_err;
    assign ovf_err   = r_ovf_err;

endmodule : freq_power_acc
`default_nettype wire

// File: tb/tb_freq_power_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_power_acc
// Description : Self-checking bench for freq_power_acc. Table of constant
//               power integrations, hand sequences for sequence errors,
//               back-to-back readout and reset, plus randomized runs scored
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_power_acc;
    import freq_pkg::*;

    localparam int FFT = c_fft_point;
    localparam int CW  = c_cnt_w;
    localparam int DW  = c_data_w;
    localparam int AW  = c_acc_w;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_sync_in;
    logic [CW-1:0]        cnt_sync_in;
    logic signed [DW-1:0] re_in, im_in;
    logic [15:0]          acc_len;
    logic                 out_valid;
    logic [CW-1:0]        out_bin;
    logic [AW-1:0]        out_data;
    logic                 sync_err, ovf_err;

    always #5 clk = ~clk;

    freq_power_acc dut (
        .clk         (clk),
        .rst         (rst),
        .en_sync_in  (en_sync_in),
        .cnt_sync_in (cnt_sync_in),
        .re_in       (re_in),
        .im_in       (im_in),
        .acc_len     (acc_len),
        .out_valid   (out_valid),
        .out_bin     (out_bin),
        .out_data    (out_data),
        .sync_err    (sync_err),
        .ovf_err     (ovf_err)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    typedef struct {
        int          bin;
        logic [63:0] data;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    first_cyc = -1;
    int    idle_viol = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back('{int'(out_bin), out_data});
            if (first_cyc < 0) first_cyc = cyc;
        end else if (out_bin != '0 || out_data != '0) begin
            idle_viol = idle_viol + 1;
        end
    end

    // ---------------- reference model ----------------
    bit          m_run = 0;
    int          m_next, m_frame, m_len;
    logic [63:0] m_acc [FFT];
    bit          m_sync = 0, m_ovf = 0;
    int          m_last_ro = -1000000;
    int          m_done_cyc = 0;

    function automatic void model_reset();
        m_run = 0; m_sync = 0; m_ovf = 0; m_last_ro = -1000000;
        exp_q.delete();
    endfunction

    function automatic void model_sample(int cnt, int re, int im);
        logic [63:0] p;
        p = 64'(longint'(re) * longint'(re) + longint'(im) * longint'(im));
        if (m_run && cnt != m_next) begin
            m_sync = 1;
            m_run  = 0;
        end
        if (!m_run) begin
            if (cnt != 0) return;
            m_run = 1; m_frame = 0;
            m_len = (acc_len == 0) ? 1 : int'(acc_len);
        end
        m_acc[cnt] = (m_frame == 0) ? p : m_acc[cnt] + p;
        m_next = (cnt + 1) % FFT;
        if (cnt == FFT - 1) begin
            m_frame++;
            if (m_frame == m_len) begin
                m_run = 0;
                m_done_cyc = cyc;
                // A readout takes FFT cycles; a later result must wait.
                if (cyc - m_last_ro >= FFT) begin
                    m_last_ro = cyc;
                    for (int b = 0; b < FFT; b++) exp_q.push_back('{b, m_acc[b]});
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit en, input int cnt, input int re, input int im);
        en_sync_in  = en;
        cnt_sync_in = CW'(cnt);
        re_in       = DW'(re);
        im_in       = DW'(im);
        if (rst) model_reset();
        else if (en) model_sample(cnt, int'(re_in), int'(im_in));
        @(posedge clk);
        #1;
    endtask

    // pat 0: constant re/im, 1: ramp re=bin, 2: random data and gaps
    task automatic run_frames(input int nfr, input int pat, input int re, input int im, input int gap);
        int g;
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < FFT; b++) begin
                g = gap;
                if (pat == 2) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                repeat (g) step(0, 0, 0, 0);
                case (pat)
                    0:       step(1, b, re, im);
                    1:       step(1, b, b, 0);
                    default: step(1, b, int'($urandom), int'($urandom));
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_readout(input string name);
        int nbad = 0;
        int first = -1;
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({name, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (got_q[i].bin != exp_q[i].bin || got_q[i].data !== exp_q[i].data) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        if (first >= 0)
            $display("FAIL %s_entry%0d: got bin %0d data %0d expected bin %0d data %0d", name, first,
                     got_q[first].bin, got_q[first].data, exp_q[first].bin, exp_q[first].data);
        check({name, "_mismatches"}, 64'(nbad), 64'd0);
        check({name, "_idle_zero"}, 64'(idle_viol), 64'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- test table ----------------
    typedef struct {
        int          len;
        int          re;
        int          im;
        int          gap;
        logic [63:0] exp_pwr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int nb;
        tbl[0] = '{4, 3, 4, 0, 64'd100};
        tbl[1] = '{1, -(1 << 22), -(1 << 22), 0, 64'd1 << 45};
        tbl[2] = '{2, 3, 4, 2, 64'd50};
        tbl[3] = '{0, 5, 0, 0, 64'd25};
        tbl[4] = '{3, -7, 1, 1, 64'd150};

        rst = 1'b1; acc_len = 16'd1;
        idle(3);
        rst = 1'b0;
        idle_viol = 0;
        got_q.delete();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bin",   64'(out_bin),   64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_sync_err",  64'(sync_err),  64'd0);
        check("rst_ovf_err",   64'(ovf_err),   64'd0);

        // Constant-power integrations with known results.
        for (int t = 0; t < 5; t++) begin
            acc_len   = 16'(tbl[t].len);
            first_cyc = -1;
            run_frames((tbl[t].len == 0) ? 1 : tbl[t].len, 0, tbl[t].re, tbl[t].im, tbl[t].gap);
            idle(FFT + 20);
            check($sformatf("tbl%0d_latency", t), 64'(first_cyc - m_done_cyc), 64'd5);
            check($sformatf("tbl%0d_beats", t), 64'(got_q.size()), 64'(FFT));
            nb = 0;
            foreach (got_q[i]) if (got_q[i].bin != i || got_q[i].data !== tbl[t].exp_pwr) nb++;
            check($sformatf("tbl%0d_bad_bins", t), 64'(nb), 64'd0);
            check_readout($sformatf("tbl%0d_model", t));
        end

        // Ramp: power equals bin squared.
        acc_len = 16'd1;
        run_frames(1, 1, 0, 0, 0);
        idle(FFT + 20);
        nb = 0;
        foreach (got_q[i]) if (got_q[i].data !== 64'(i * i)) nb++;
        check("ramp_bad_bins", 64'(nb), 64'd0);
        check_readout("ramp");

        // Sequence break in frame 1 (100 -> 102), then a clean integration.
        check("pre_sync_err", 64'(sync_err), 64'd0);
        acc_len = 16'd2;
        run_frames(1, 0, 3, 4, 0);
        for (int b = 0; b < FFT; b++) if (b != 101) step(1, b, 3, 4);
        check("sync_err_set", 64'(sync_err), 64'd1);
        check("sync_no_output", 64'(got_q.size()), 64'd0);
        acc_len = 16'd1;
        run_frames(1, 1, 0, 0, 0);
        idle(FFT + 20);
        check("sync_clean_beats", 64'(got_q.size()), 64'(FFT));
        check("sync_model_flag", 64'(sync_err), 64'(m_sync));
        check_readout("sync_recover");

        // Back-to-back single-spectrum integrations at full rate.
        acc_len = 16'd1;
        run_frames(3, 2, 0, 0, 0);
        for (int b = 0; b < 2 * FFT; b++) step(1, b % FFT, b, -b);
        idle(FFT + 20);
        check("b2b_beats", 64'(got_q.size()), 64'(5 * FFT));
        check("b2b_ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("b2b_ovf_zero", 64'(ovf_err), 64'd0);
        check_readout("b2b");

        // Reset at bin 200 of frame 2.
        acc_len = 16'd3;
        run_frames(2, 0, 1, 2, 0);
        for (int b = 0; b < 200; b++) step(1, b, 1, 2);
        rst = 1'b1;
        step(1, 200, 1, 2);
        rst = 1'b0;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_data",  out_data,       64'd0);
        check("rst_mid_sync_err",  64'(sync_err),  64'd0);
        idle(FFT + 20);
        check("rst_mid_no_output", 64'(got_q.size()), 64'd0);

        // Reset in the middle of a readout.
        acc_len = 16'd1;
        run_frames(1, 0, 1, 1, 0);
        idle(100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_ro_out_valid", 64'(out_valid), 64'd0);
        check("rst_ro_out_bin",   64'(out_bin),   64'd0);
        check("rst_ro_out_data",  out_data,       64'd0);
        got_q.delete();
        idle(20);
        check("rst_ro_aborted", 64'(got_q.size()), 64'd0);

        // Fresh randomized integrations after reset.
        for (int r = 0; r < 2; r++) begin
            acc_len = 16'($urandom_range(1, 3));
            run_frames(int'(acc_len), 2, 0, 0, 0);
            idle(FFT + 20);
            check_readout($sformatf("rand%0d", r));
        end
        check("final_sync_err", 64'(sync_err), 64'(m_sync));
        check("final_ovf_err",  64'(ovf_err),  64'(m_ovf));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_freq_power_acc
`default_nettype wire

// File: doc/freq_power_acc.md
FREQ_POWER_ACC -- requirements
Module: freq_power_acc

Interface
REQ-001 SHALL have parameter FFT_POINT, default 512, bins per spectrum.
REQ-002 SHALL have parameter CNT_W, default 9, bin index width (log2 FFT_POINT).
REQ-003 SHALL have parameter DATA_W, default 23, width of signed re/im input.
REQ-004 SHALL have parameter ACC_W, default 64, accumulator/output width.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en_sync_in  in  1  sample valid, from equalizer multiplier stage.
REQ-008 cnt_sync_in  in  CNT_W  bin index of current sample, 0..FFT_POINT-1.
REQ-009 re_in, im_in  in  DATA_W each  equalized real/imag, two's complement.
REQ-010 acc_len  in  16  spectra per integration; sampled at integration start.
REQ-011 out_valid  out  1  strobe, one per output bin.
REQ-012 out_bin  out  CNT_W  bin index of out_data.
REQ-013 out_data  out  ACC_W  unsigned integrated power of out_bin.
REQ-014 sync_err  out  1  sticky: bin sequence violation seen.
REQ-015 ovf_err  out  1  sticky: integration completed while readout busy.

Function
REQ-016 Per accepted sample SHALL compute power = re*re + im*im, 2*DATA_W unsigned bits, exact.
REQ-017 Sample accepted only when en_sync_in=1; gaps of any length between samples SHALL be tolerated.
REQ-018 State machine SHALL have states WAIT_SOF and ACCUM; reset state WAIT_SOF.
REQ-019 WAIT_SOF -> ACCUM on accepted sample with cnt_sync_in=0; that sample is first of integration; acc_len latched, acc_len=0 treated as 1.
REQ-020 In ACCUM, each accepted sample SHALL carry cnt_sync_in = previous+1 (wrapping FFT_POINT-1 -> 0); otherwise set sync_err, discard current integration, go to WAIT_SOF (offending sample treated per REQ-019 if cnt=0).
REQ-021 Frame counter SHALL increment on accepted sample with cnt=FFT_POINT-1; integration completes on that sample in frame acc_len-1.
REQ-022 Two accumulator banks (ping-pong), FFT_POINT x ACC_W each; one accumulates, other reads out.
REQ-023 In frame 0 of an integration, bank[bin] SHALL be written with power (overwrite, no clear pass); later frames with bank[bin]+power.
REQ-024 Read-modify-write pipeline: input register, square, sum, write; write of a bin SHALL occur exactly 3 cycles after its acceptance; no same-bin hazard exists since a bin recurs at most every FFT_POINT cycles.
REQ-025 On integration completion (after final write), banks SHALL swap and readout SHALL start; next integration starts per REQ-019 without waiting.
REQ-026 Readout SHALL emit bins 0..FFT_POINT-1 on consecutive cycles, out_valid high FFT_POINT cycles, first out_valid 2 cycles after final write.
REQ-027 If completion occurs while readout busy: set ovf_err, do not swap, discard that integration's result, restart accumulation in same bank.
REQ-028 Accumulator SHALL not overflow for acc_len<=65535 at ACC_W=64; no saturation logic.
REQ-029 out_bin, out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-030 rst SHALL force WAIT_SOF, frame counter 0, bank select 0, readout idle, out_valid=0, out_bin=0, out_data=0, sync_err=0, ovf_err=0.
REQ-031 rst mid-integration or mid-readout SHALL abort both; RAM contents need not be cleared; in-flight pipeline writes SHALL be suppressed.

Structure
REQ-032 FFT_POINT, CNT_W, DATA_W, ACC_W defaults and state encoding SHALL live in shared package freq_pkg.
REQ-033 Accumulator storage SHALL be sub-module freq_power_ram: simple dual-port, one write, one read, 1-cycle read latency; instantiated twice.

Verification
REQ-034 acc_len=4, 4 contiguous frames, re=3, im=4 all bins -> 512 out_valid cycles, out_data=100 every bin, out_bin 0..511.
REQ-035 acc_len=1, re=-(2^22), im=-(2^22) -> out_data=2^45 each bin; ramp re=bin, im=0 -> out_data=bin^2.
REQ-036 acc_len=2, en_sync_in toggling 1-in-3 -> results identical to contiguous case (power 25 -> 50).
REQ-037 Frame 1 jumps cnt 100->102 -> sync_err=1, no out_valid for that integration; next clean integration from cnt=0 -> correct output.
REQ-038 acc_len=1 back-to-back frames at full rate -> every frame read out, ovf_err stays 0; acc_len=0 behaves as 1.
REQ-039 rst asserted at bin 200 of frame 2 and mid-readout -> all outputs 0 next cycle; fresh integration afterwards correct.
